cpu_fetch_queue: RTL

CPU_FETCH_QUEUE -- requirements
Module: cpu_fetch_queue

---
 rtl/cpu_fetch_queue_if.sv | 29 ++
 rtl/cpu_fetch_queue.sv | 117 +++++++++++
 2 files changed

// File: rtl/cpu_fetch_queue_if.sv
// Fetch-queue bundle: memory request/response channel, redirect and the
// decode-side handshake. The queue drives through master; memory/decode use slave.
interface cpu_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;
  logic            instr_fault;

  modport master (
    output req_valid, req_addr, instr_valid, instr_data, instr_pc, instr_fault,
    input  req_ready, rsp_valid, rsp_data, rsp_err, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  req_valid, req_addr, instr_valid, instr_data, instr_pc, instr_fault,
    output req_ready, rsp_valid, rsp_data, rsp_err, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/cpu_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, reorders nothing (memory is in
// order), buffers up to DEPTH entries for decode and discards stale data after redirects.
module cpu_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst,
  cpu_fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Discard must absorb stale beats from several back-to-back redirects.
  localparam int DW = PW + 4;

  typedef struct packed {
    logic            reserved;
    logic            filled;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            fault;
  } slot_t;

  slot_t           slots [DEPTH];
  slot_t           head;
  logic [XLEN-1:0] fetch_pc;
  logic [PW-1:0]   issue_ptr;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   head_ptr;
  logic [CW-1:0]   res_count;
  logic [CW-1:0]   pending;
  logic [DW-1:0]   discard;
  logic [DW-1:0]   redirect_discard;
  logic            issue;
  logic            fill;
  logic            drop;
  logic            pop;

  assign bus.req_valid = !rst && !bus.redirect && (res_count < CW'(DEPTH));
  assign bus.req_addr  = fetch_pc;

  assign issue = bus.req_valid && bus.req_ready;
  assign fill  = bus.rsp_valid && (discard == '0) && (pending != '0);
  assign drop  = bus.rsp_valid && (discard != '0);
  assign pop   = bus.instr_valid && bus.instr_ready;

  assign head            = slots[head_ptr];
  assign bus.instr_valid = head.filled;
  assign bus.instr_data  = head.data;
  assign bus.instr_pc    = head.pc;
  assign bus.instr_fault = head.fault;

  // Everything still in flight at a redirect comes back stale, less any beat landing now.
  always_comb begin
    redirect_discard = discard + DW'(pending);
    if (bus.rsp_valid && (redirect_discard != '0))
      redirect_discard = redirect_discard - DW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        slots[i] <= '0;
      fetch_pc  <= RESET_PC;
      issue_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      res_count <= '0;
      pending   <= '0;
      discard   <= '0;
    end else if (bus.redirect) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i].reserved <= 1'b0;
        slots[i].filled   <= 1'b0;
      end
      fetch_pc  <= bus.redirect_pc;
      issue_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      res_count <= '0;
      pending   <= '0;
      discard   <= redirect_discard;
    end else begin
      if (issue) begin
        slots[issue_ptr].reserved <= 1'b1;
        slots[issue_ptr].pc       <= fetch_pc;
        issue_ptr                 <= issue_ptr + PW'(1);
        fetch_pc                  <= fetch_pc + XLEN'(4);
      end
      if (fill) begin
        slots[fill_ptr].filled <= 1'b1;
        slots[fill_ptr].data   <= bus.rsp_data;
        slots[fill_ptr].fault  <= bus.rsp_err;
        fill_ptr               <= fill_ptr + PW'(1);
      end
      if (drop)
        discard <= discard - DW'(1);
      if (pop) begin
        slots[head_ptr].reserved <= 1'b0;
        slots[head_ptr].filled   <= 1'b0;
        head_ptr                 <= head_ptr + PW'(1);
      end
      res_count <= res_count + CW'(issue) - CW'(pop);
      pending   <= pending + CW'(issue) - CW'(fill);
    end
  end

  // A beat with nothing outstanding is silently ignored; make it visible in coverage.
  cover property (@(posedge clk) disable iff (rst)
    bus.rsp_valid && (discard == '0) && (pending == '0));

  assert property (@(posedge clk) disable iff (rst)
    !(fill && pop && (fill_ptr == head_ptr)));

endmodule
